// File: rtl/rf_pkg.sv
// Shared constants and elaboration-time helpers for the multi-port register file.
// Optional read bypass in register_file_mp is enabled with RF_BYPASS_EN.
package rf_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_NRD   = 2;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // The hardwired-zero register sits at the top of the index space by default.
    function automatic int defaultZeroIdx(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: tracks in-flight producers per register and keeps a
// registered population count of the pending bits.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ZERO_IDX = defaultZeroIdx(DEPTH),
    parameter int AW       = clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             RegWr,
    input  logic [AW-1:0]    RW,
    input  logic             RsvEn,
    input  logic [AW-1:0]    RsvIdx,
    output logic [DEPTH-1:0] pend,
    output logic [AW:0]      PendCnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic             setHit;
    logic             clrHit;
    logic             incCnt;
    logic             decCnt;
    logic [DEPTH-1:0] pendNext;

    // The set is applied after the clear so a same-register reserve wins over the write.
    always_comb begin
        setHit   = RsvEn && (RsvIdx != ZERO_ADDR);
        clrHit   = RegWr && (RW != ZERO_ADDR);
        pendNext = pend;
        if (clrHit) pendNext[RW] = 1'b0;
        if (setHit) pendNext[RsvIdx] = 1'b1;
        incCnt = setHit && !pend[RsvIdx];
        decCnt = clrHit && pend[RW] && !(setHit && (RsvIdx == RW));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend    <= '0;
            PendCnt <= '0;
        end else begin
            pend <= pendNext;
            if (incCnt && !decCnt)
                PendCnt <= PendCnt + CNT_ONE;
            else if (decCnt && !incCnt)
                PendCnt <= PendCnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with a hardwired-zero register and pending scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int NRD      = DEFAULT_NRD,
    parameter int ZERO_IDX = defaultZeroIdx(DEPTH),
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NRD*AW-1:0]    RdAddr,
    output logic [NRD*WIDTH-1:0] RdData,
    output logic [NRD-1:0]       RdPend,
    input  logic                 RegWr,
    input  logic [AW-1:0]        RW,
    input  logic [WIDTH-1:0]     BusW,
    input  logic                 RsvEn,
    input  logic [AW-1:0]        RsvIdx,
    output logic [AW:0]          PendCnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [AW-1:0]    portAddr;

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_IDX (ZERO_IDX),
        .AW       (AW)
    ) scoreboard (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .RegWr   (RegWr),
        .RW      (RW),
        .RsvEn   (RsvEn),
        .RsvIdx  (RsvIdx),
        .pend    (pend),
        .PendCnt (PendCnt)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (RegWr && (RW != ZERO_ADDR)) begin
            regs[RW] <= BusW;
        end
    end

    // The zero register is masked on read, so its storage contents never matter.
    always_comb begin
        RdData   = '0;
        RdPend   = '0;
        portAddr = '0;
        for (int k = 0; k < NRD; k++) begin
            portAddr = RdAddr[k*AW +: AW];
            if (portAddr != ZERO_ADDR) begin
                RdData[k*WIDTH +: WIDTH] = regs[portAddr];
                RdPend[k]                = pend[portAddr];
`ifdef RF_BYPASS_EN
                if (RegWr && (RW == portAddr)) begin
                    RdData[k*WIDTH +: WIDTH] = BusW;
                    RdPend[k]                = RsvEn && (RsvIdx == portAddr);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp at default parameters
// (64-bit data, 32 registers, 2 read ports, R31 hardwired to zero).
module tb_register_file_mp;

    localparam int WIDTH = 64;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                 Clk;
    logic                 Rst_n;
    logic [NRD*AW-1:0]    RdAddr;
    logic [NRD*WIDTH-1:0] RdData;
    logic [NRD-1:0]       RdPend;
    logic                 RegWr;
    logic [AW-1:0]        RW;
    logic [WIDTH-1:0]     BusW;
    logic                 RsvEn;
    logic [AW-1:0]        RsvIdx;
    logic [AW:0]          PendCnt;

    int checks;
    int errors;

    register_file_mp dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .RdAddr  (RdAddr),
        .RdData  (RdData),
        .RdPend  (RdPend),
        .RegWr   (RegWr),
        .RW      (RW),
        .BusW    (BusW),
        .RsvEn   (RsvEn),
        .RsvIdx  (RsvIdx),
        .PendCnt (PendCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [WIDTH-1:0] portData(input int k);
        return RdData[k*WIDTH +: WIDTH];
    endfunction

    task automatic setRead(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RdAddr = {a1, a0};
    endtask

    // One clock of stimulus; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] rw,
                                 input logic [WIDTH-1:0] busw,
                                 input logic rsv, input logic [AW-1:0] ridx);
        RegWr  = wr;
        RW     = rw;
        BusW   = busw;
        RsvEn  = rsv;
        RsvIdx = ridx;
        @(posedge Clk);
        #1;
        RegWr = 1'b0;
        RsvEn = 1'b0;
    endtask

    task automatic test_reset;
        setRead(5'd0, 5'd3);
        #1;
        checks++;
        if (RdData !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", RdData);
        end
        checks++;
        if (PendCnt !== 6'd0 || RdPend !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_pend: cnt %0d pend %b expected 0 00", PendCnt, RdPend);
        end
    endtask

    task automatic test_write_read;
        applyStimulus(1'b1, 5'd5, 64'hDEADBEEF, 1'b0, 5'd0);
        setRead(5'd5, 5'd5);
        #1;
        checks++;
        if (portData(0) !== 64'hDEADBEEF || portData(1) !== 64'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_read_r5: got %h %h expected deadbeef", portData(0), portData(1));
        end
        applyStimulus(1'b1, 5'd31, 64'hFFFF_0000_1111_2222, 1'b1, 5'd31);
        setRead(5'd31, 5'd5);
        #1;
        checks++;
        if (portData(0) !== 64'd0 || RdPend[0] !== 1'b0 || PendCnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL zero_reg: data %h pend %b cnt %0d expected 0 0 0", portData(0), RdPend[0], PendCnt);
        end
    endtask

    task automatic test_scoreboard;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
        setRead(5'd7, 5'd0);
        #1;
        checks++;
        if (RdPend[0] !== 1'b1 || PendCnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL reserve_r7: pend %b cnt %0d expected 1 1", RdPend[0], PendCnt);
        end
        applyStimulus(1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
        checks++;
        if (RdPend[0] !== 1'b0 || PendCnt !== 6'd0 || portData(0) !== 64'h77) begin
            errors++;
            $display("[TB] FAIL write_r7: pend %b cnt %0d data %h expected 0 0 77", RdPend[0], PendCnt, portData(0));
        end
        applyStimulus(1'b1, 5'd8, 64'h88, 1'b0, 5'd0);
        checks++;
        if (PendCnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL write_nonpending: cnt %0d expected 0", PendCnt);
        end
    endtask

    task automatic test_same_cycle;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
        applyStimulus(1'b1, 5'd9, 64'h9999, 1'b1, 5'd9);
        setRead(5'd9, 5'd10);
        #1;
        checks++;
        if (portData(0) !== 64'h9999 || RdPend[0] !== 1'b1 || PendCnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL same_reg_wr_rsv: data %h pend %b cnt %0d expected 9999 1 1", portData(0), RdPend[0], PendCnt);
        end
        applyStimulus(1'b1, 5'd9, 64'hAAAA, 1'b1, 5'd10);
        checks++;
        if (RdPend !== 2'b10 || PendCnt !== 6'd1 || portData(0) !== 64'hAAAA) begin
            errors++;
            $display("[TB] FAIL diff_reg_wr_rsv: pend %b cnt %0d data %h expected 10 1 aaaa", RdPend, PendCnt, portData(0));
        end
        applyStimulus(1'b1, 5'd10, 64'h1010, 1'b0, 5'd0);
        checks++;
        if (RdPend !== 2'b00 || PendCnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL clear_r10: pend %b cnt %0d expected 00 0", RdPend, PendCnt);
        end
    endtask

    task automatic test_bypass;
        applyStimulus(1'b1, 5'd2, 64'h11, 1'b0, 5'd0);
        setRead(5'd0, 5'd2);
        RegWr = 1'b1;
        RW    = 5'd2;
        BusW  = 64'hA5;
        #1;
        checks++;
`ifdef RF_BYPASS_EN
        if (portData(1) !== 64'hA5) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected a5", portData(1));
        end
`else
        if (portData(1) !== 64'h11) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected 11", portData(1));
        end
`endif
        @(posedge Clk);
        #1;
        RegWr = 1'b0;
        checks++;
        if (portData(1) !== 64'hA5) begin
            errors++;
            $display("[TB] FAIL bypass_after_edge: got %h expected a5", portData(1));
        end
    endtask

    task automatic test_reset_midrun;
        applyStimulus(1'b1, 5'd3, 64'h1234, 1'b1, 5'd4);
        setRead(5'd3, 5'd4);
        #1;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (portData(0) !== 64'd0 || PendCnt !== 6'd0 || RdPend !== 2'b00) begin
            errors++;
            $display("[TB] FAIL async_reset: data %h cnt %0d pend %b expected 0 0 00", portData(0), PendCnt, RdPend);
        end
        #2;
        Rst_n = 1'b1;
        applyStimulus(1'b1, 5'd3, 64'h55, 1'b0, 5'd0);
        checks++;
        if (portData(0) !== 64'h55) begin
            errors++;
            $display("[TB] FAIL first_write_after_reset: got %h expected 55", portData(0));
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'(i));
        setRead(5'd30, 5'd0);
        #1;
        checks++;
        if (PendCnt !== 6'd31 || RdPend !== 2'b11) begin
            errors++;
            $display("[TB] FAIL saturate: cnt %0d pend %b expected 31 11", PendCnt, RdPend);
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd4);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd31);
        checks++;
        if (PendCnt !== 6'd31) begin
            errors++;
            $display("[TB] FAIL rereserve: cnt %0d expected 31", PendCnt);
        end
        applyStimulus(1'b1, 5'd30, 64'h30, 1'b0, 5'd0);
        checks++;
        if (PendCnt !== 6'd30 || RdPend[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_one: cnt %0d pend %b expected 30 0", PendCnt, RdPend[0]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        Rst_n  = 1'b0;
        RegWr  = 1'b0;
        RW     = '0;
        BusW   = '0;
        RsvEn  = 1'b0;
        RsvIdx = '0;
        RdAddr = '0;
        repeat (2) @(posedge Clk);
        test_reset;
        #2;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        test_write_read;
        test_scoreboard;
        test_same_cycle;
        test_bypass;
        test_reset_midrun;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count, a power of two and at least 4.
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter ZERO_IDX, default DEPTH-1, meaning the index of the hardwired-zero register.
REQ-005 SHALL derive local AW = log2(DEPTH).
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-007 SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port RdAddr, input, NRD*AW bits: read addresses; port k uses slice [k*AW +: AW].
REQ-009 SHALL have port RdData, output, NRD*WIDTH bits: read data; port k uses slice [k*WIDTH +: WIDTH].
REQ-010 SHALL have port RdPend, output, NRD bits: pending flag of each read register.
REQ-011 SHALL have ports RegWr (input, 1 bit), RW (input, AW bits) and BusW (input, WIDTH bits): the write enable, write address and write data.
REQ-012 SHALL have ports RsvEn (input, 1 bit) and RsvIdx (input, AW bits): mark a register pending (in-flight producer).
REQ-013 SHALL have port PendCnt, output, AW+1 bits: number of registers currently pending.

Function
REQ-014 SHALL store DEPTH registers of WIDTH bits and DEPTH pending bits.
REQ-015 SHALL make reads combinational: RdData[k] = reg[RdAddr[k]] and RdPend[k] = pend[RdAddr[k]], independently per port.
REQ-016 SHALL make ZERO_IDX always read as 0 with pending 0; writes and reservations to it are ignored.
REQ-017 SHALL update reg[RW] <= BusW on the rising Clk edge when RegWr=1 and RW != ZERO_IDX.
REQ-018 SHALL clear pend[RW] on that same edge.
REQ-019 SHALL set pend[RsvIdx] on the rising edge when RsvEn=1 and RsvIdx != ZERO_IDX.
REQ-020 SHALL, when a write and a reserve target the same register in one cycle, store the data and leave pend set, because the reserve (newer producer) wins.
REQ-021 SHALL, when a write and a reserve target different registers in one cycle, apply both.
REQ-022 SHALL keep PendCnt registered and equal to the population count of pend after every edge: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 for simultaneous set and clear; it never exceeds DEPTH-1.
REQ-023 SHALL ignore a reserve of an already-pending register (no count change) and a write to a non-pending register (count unchanged).

Reset
REQ-024 SHALL, while Rst_n=0, asynchronously clear all registers to 0, all pend bits to 0 and PendCnt to 0.
REQ-025 SHALL leave RdData and RdPend reading 0 during reset.
REQ-026 SHALL abandon any write or reserve coinciding with reset assertion.
REQ-027 SHALL apply the first write on the first rising edge after Rst_n deasserts.

Configuration
REQ-028 SHALL, with RF_BYPASS_EN defined, forward BusW to RdData[k] combinationally when RegWr=1, RW==RdAddr[k] and RW != ZERO_IDX; RdPend[k] then reads 0 unless RsvEn targets the same index.
REQ-029 SHALL, without RF_BYPASS_EN, have reads return the stored pre-edge value and pend until the write edge, with no combinational path from BusW to RdData.

Structure
REQ-030 SHALL place the clog2 helper function, default WIDTH/DEPTH constants and the ZERO_IDX default in shared package rf_pkg.
REQ-031 SHALL implement the pend bit array plus PendCnt bookkeeping in one sub-module, rf_scoreboard; the data array and read muxing stay in register_file_mp.

Verification
REQ-032 SHALL cover reset: Rst_n=0 mid-run after writing 0x1234 to R3 -> RdData for R3 = 0 and PendCnt = 0 immediately, without waiting for Clk.
REQ-033 SHALL cover basic write/read: RegWr=1, RW=5, BusW=0xDEADBEEF -> after edge, both read ports at addr 5 = 0xDEADBEEF; a write to R31 leaves it reading 0.
REQ-034 SHALL cover the scoreboard: RsvEn on R7 -> RdPend=1 and PendCnt=1; a later write to R7 -> RdPend=0 and PendCnt=0.
REQ-035 SHALL cover same-cycle reserve and write on R9 (R9 pending before) -> data stored, RdPend=1, PendCnt unchanged.
REQ-036 SHALL cover the bypass: in the same cycle as a write of 0xA5 to R2, read port 1 addr 2 -> 0xA5 with RF_BYPASS_EN, old value without it.
REQ-037 SHALL cover saturation: reserve all DEPTH-1 non-zero registers -> PendCnt = DEPTH-1; a re-reserve of any -> unchanged.
